mux_nto1_pipe: RTL and testbench

//  Parametrised N-to-1 channel selector with a registered output stage and valid/ready handshake.

---
 rtl/mux_pipe_pkg.sv | 24 ++
 rtl/mux_pipe_stage.sv | 33 +++
 rtl/mux_nto1_pipe.sv | 104 ++++++++++
 tb/tb_mux_nto1_pipe.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pipe_pkg.sv
// Shared types and helpers for the N-to-1 pipelined channel selector.
// Entries are carried at maximum width; instances use the low DATA_W/SEL_W bits.
package mux_pipe_pkg;

    localparam int MUX_MAX_CH = 16;
    localparam int MUX_MAX_DW = 32;
    localparam int MUX_MAX_SW = 8;
    localparam int MUX_IDX_W  = 4;

    typedef struct packed {
        logic [MUX_MAX_DW-1:0] data;
        logic [MUX_MAX_SW-1:0] sel;
        logic                  err;
    } pipe_entry_t;

    // Channels sit at a fixed MUX_MAX_DW stride in the padded flat vector.
    function automatic logic [MUX_MAX_DW-1:0] chan_slice(
        input logic [MUX_MAX_CH*MUX_MAX_DW-1:0] flat,
        input logic [MUX_IDX_W-1:0]             idx
    );
        return MUX_MAX_DW'(flat >> (int'(idx) * MUX_MAX_DW));
    endfunction

endpackage

// File: rtl/mux_pipe_stage.sv
// One pipe entry register with valid flag: load captures d, clr drops valid, else hold.
// Synchronous active-low reset clears both entry and valid.
module mux_pipe_stage
    import mux_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clr,
    input  pipe_entry_t d,
    output pipe_entry_t q,
    output logic        q_valid
);

    pipe_entry_t q_reg;
    logic        valid_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_reg     <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            q_reg     <= d;
            valid_reg <= 1'b1;
        end else if (clr) begin
            valid_reg <= 1'b0;
        end
    end

    assign q       = q_reg;
    assign q_valid = valid_reg;

endmodule

// File: rtl/mux_nto1_pipe.sv
// N-to-1 channel selector with registered output and valid/ready handshake.
// Define MUX_PIPE_SKID_EN to add a 1-entry skid so in_ready has no out_ready path.
module mux_nto1_pipe
    import mux_pipe_pkg::*;
#(
    parameter int DATA_W = 5,
    parameter int N_CH   = 2,
    parameter int SEL_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sel_err
);

    logic [MUX_MAX_CH*MUX_MAX_DW-1:0] ch_flat;
    logic [MUX_IDX_W-1:0]             ch_idx;
    logic                             sel_bad;
    pipe_entry_t                      new_entry;
    pipe_entry_t                      out_d;
    pipe_entry_t                      out_q;
    logic                             out_load;
    logic                             out_clr;
    logic                             accept;
    logic                             transfer;

    // Re-pack channels at a fixed stride; absent channels read as zero.
    for (genvar gi = 0; gi < MUX_MAX_CH; gi++) begin : g_ch
        if (gi < N_CH) begin : g_live
            assign ch_flat[gi*MUX_MAX_DW +: MUX_MAX_DW] = MUX_MAX_DW'(in_data[gi*DATA_W +: DATA_W]);
        end else begin : g_pad
            assign ch_flat[gi*MUX_MAX_DW +: MUX_MAX_DW] = '0;
        end
    end

    // Out-of-range selects fall back to channel 0 and are flagged.
    always_comb begin
        sel_bad        = (32'(in_sel) >= N_CH);
        ch_idx         = sel_bad ? '0 : MUX_IDX_W'(in_sel);
        new_entry      = '0;
        new_entry.data = chan_slice(ch_flat, ch_idx);
        new_entry.sel  = MUX_MAX_SW'(in_sel);
        new_entry.err  = sel_bad;
    end

    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;

`ifdef MUX_PIPE_SKID_EN
    pipe_entry_t skid_q;
    logic        skid_valid;
    logic        skid_load;
    logic        skid_clr;

    // Skid only ever holds the request accepted behind a stalled output.
    assign in_ready  = !skid_valid;
    assign skid_load = accept && out_valid && !out_ready;
    assign skid_clr  = transfer && skid_valid;
    assign out_load  = (accept && (!out_valid || out_ready)) || (transfer && skid_valid);
    assign out_clr   = transfer && !out_load;
    assign out_d     = skid_valid ? skid_q : new_entry;

    mux_pipe_stage u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load),
        .clr     (skid_clr),
        .d       (new_entry),
        .q       (skid_q),
        .q_valid (skid_valid)
    );
`else
    assign in_ready = !out_valid || out_ready;
    assign out_load = accept;
    assign out_clr  = transfer && !accept;
    assign out_d    = new_entry;
`endif

    mux_pipe_stage u_out (
        .clk     (clk),
        .reset   (reset),
        .load    (out_load),
        .clr     (out_clr),
        .d       (out_d),
        .q       (out_q),
        .q_valid (out_valid)
    );

    assign out_data = out_q.data[DATA_W-1:0];
    assign out_sel  = out_q.sel[SEL_W-1:0];
    assign sel_err  = out_q.err;

    // Upper entry bits are constant zero padding.
    logic unused_out_bits;
    assign unused_out_bits = ^{out_q.data, out_q.sel};

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Self-checking bench for mux_nto1_pipe (N_CH=3, DATA_W=5); queue model plus directed literals.
// Works in both builds; MUX_PIPE_SKID_EN selects the 2-deep expectations.
module tb_mux_nto1_pipe;

    localparam int DATA_W = 5;
    localparam int N_CH   = 3;
    localparam int SEL_W  = 4;
`ifdef MUX_PIPE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_CH*DATA_W-1:0] in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      out_data;
    logic [SEL_W-1:0]       out_sel;
    logic                   out_valid;
    logic                   out_ready;
    logic                   sel_err;

    mux_nto1_pipe #(.DATA_W(DATA_W), .N_CH(N_CH), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int sel;
        int err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   check_en = 1'b0;
    bit   verbose  = 1'b1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int ch_val(int k);
        logic [N_CH*DATA_W-1:0] v;
        v = in_data >> (k * DATA_W);
        return int'(v[DATA_W-1:0]);
    endfunction

    // Accept capacity: one entry without skid (ready also when draining), two with skid.
    function automatic bit model_ready();
        if (DEPTH == 1) return (q.size() == 0) || out_ready;
        return q.size() < 2;
    endfunction

    always @(posedge clk) begin
        bit   acc;
        bit   xfer;
        exp_t e;
        acc  = in_valid && model_ready();
        xfer = (q.size() > 0) && out_ready;
        if (!reset) begin
            q.delete();
        end else begin
            if (acc) begin
                e.sel  = int'(in_sel);
                e.err  = (int'(in_sel) >= N_CH) ? 1 : 0;
                e.data = ch_val(e.err ? 0 : e.sel);
            end
            if (xfer) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("in_ready", 32'(in_ready), 32'(model_ready()));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("out_data", 32'(out_data), 32'(q[0].data));
                chk("out_sel", 32'(out_sel), 32'(q[0].sel));
                chk("sel_err", 32'(sel_err), 32'(q[0].err));
                if (verbose && out_ready)
                    $display("xfer data=%0d sel=%0d err=%0d t=%0t", out_data, out_sel, sel_err, $time);
            end
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 4'd1;
        in_data   = {5'd16, 5'd17, 5'd3};
        out_ready = 1'b1;

        // Reset held three cycles with a request pending.
        repeat (3) begin
            step();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_data", 32'(out_data), 32'd0);
            chk("rst_sel_err", 32'(sel_err), 32'd0);
            check_en = 1'b1;
        end

        // Back-to-back pass-through.
        reset = 1'b1;
        step();
        chk("pass0_data", 32'(out_data), 32'd17);
        chk("pass0_ready", 32'(in_ready), 32'd1);
        in_sel = 4'd2;
        step();
        chk("pass1_data", 32'(out_data), 32'd16);
        chk("pass1_ready", 32'(in_ready), 32'd1);
        in_sel = 4'd0;
        step();
        chk("pass2_data", 32'(out_data), 32'd3);
        chk("pass2_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();
        chk("pass_drain_valid", 32'(out_valid), 32'd0);

        // Stall with a second request offered.
        in_valid = 1'b1;
        in_sel   = 4'd1;
        step();
        out_ready = 1'b0;
        in_sel    = 4'd2;
        #1;
`ifdef MUX_PIPE_SKID_EN
        chk("stall_ready0", 32'(in_ready), 32'd1);
`else
        chk("stall_ready0", 32'(in_ready), 32'd0);
`endif
        repeat (4) begin
            step();
            chk("stall_data", 32'(out_data), 32'd17);
            chk("stall_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
`ifdef MUX_PIPE_SKID_EN
        chk("skid_drain_data", 32'(out_data), 32'd16);
        chk("skid_drain_valid", 32'(out_valid), 32'd1);
        step();
`endif
        chk("stall_end_valid", 32'(out_valid), 32'd0);

        // Out-of-range select.
        in_data  = {5'd16, 5'd17, 5'd9};
        in_valid = 1'b1;
        in_sel   = 4'd3;
        step();
        chk("bad_data", 32'(out_data), 32'd9);
        chk("bad_err", 32'(sel_err), 32'd1);
        chk("bad_sel", 32'(out_sel), 32'd3);
        in_sel = 4'd1;
        step();
        chk("good_data", 32'(out_data), 32'd17);
        chk("good_err", 32'(sel_err), 32'd0);
        in_valid = 1'b0;
        step();

        // Reset while stalled with requests pending.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 4'd1;
        step();
        in_sel = 4'd2;
        step();
        in_valid = 1'b0;
`ifdef MUX_PIPE_SKID_EN
        chk("pend_ready", 32'(in_ready), 32'd0);
`endif
        reset = 1'b0;
        step();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        step();
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // Random traffic against the queue model.
        verbose = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 6);
            in_sel    = 4'($urandom_range(0, 4));
            in_data   = 15'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(3);
        chk("final_drain_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
